adder_i8_i8_i8: RTL and testbench
=================================

// Module: adder_i8_i8_i8
// PURPOSE
// - 8-bit integer adder leaf block (i8 + i8 -> i8) for compiler-generated datapaths.
// - y is the wrap-around (mod 256) sum of a and b; same result for signed and unsigned operands.
// - Purely combinational datapath; zero-cycle latency.
// - Clock and reset exist so the port list matches every other generated operator.
// PARAMETERS
// - WIDTH  8  operand/result width in bits; only 8 is supported, elaborate-time error otherwise
// PORTS
// - clock  input   1      system clock; single clock domain; unused by the datapath
// - reset  input   1      synchronous, active-high reset; unused by the datapath
// - a      input   WIDTH  addend operand
// - b      input   WIDTH  addend operand
// - y      output  WIDTH  sum, (a + b) mod 2^WIDTH
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - y = a + b, truncated to 8 bits; carry-out and overflow are discarded, no status outputs.
// - Latency 0: y follows a/b within the same cycle and is valid whenever the inputs are stable.
// - No registers anywhere in the datapath, so y has no reset value.
// - During reset, y still equals a + b of the current inputs; reset never forces y to 0.
// - A consumer sampling y on the first posedge after reset deasserts must read the sum of the
//   operands held during reset.
// - Structure: explicit bit-level carry chain.
//   - p[i] = a[i]^b[i], g[i] = a[i]&b[i], c[0] = 0
//   - c[i+1] = g[i] | (p[i] & c[i]), y[i] = p[i] ^ c[i]
//   - c[8] is dropped.
// - Wrap-around: 255 + 1 -> 0; 128 + 128 -> 0; 127 + 1 -> 128 (0x80, signed overflow, not flagged).
// - No X-propagation guards: X or Z on an input bit may propagate to y.
// - No latches and no combinational loops.
// - clock and reset drive no logic; tie them off internally to avoid lint warnings.
// TESTING
// - Hold reset for 16 cycles with a=9, b=3; at the first posedge after reset falls -> y == 12.
// - Apply a=255, b=1 -> y == 0 in the same cycle (carry-out dropped).
// - Apply a=127, b=1 -> y == 128; a=128, b=128 -> y == 0.
// - Apply a=0xAA, b=0x55 -> y == 0xFF.
//   - Then a=0x55, b=0x55 -> y == 0xAA (alternating carries exercised).
// - Exhaustive sweep: all 65536 (a,b) pairs checked against (a+b)&8'hFF; assert reset mid-sweep
//   -> y unaffected.

Source files
------------

// File: rtl/adder_i8_i8_i8.sv
// 8-bit wrap-around adder (y = a + b mod 256) with an explicit ripple-carry chain.
// Latency 0; no flow control; clock/reset are present only for port-list uniformity.
module adder_i8_i8_i8 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    if (WIDTH != 8) begin : g_width_check
        $error("adder_i8_i8_i8: only WIDTH == 8 is supported");
    end

    // Each stage owns its carry signals so the chain never feeds back into a single vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_p;
        logic w_g;
        logic w_cin;
        logic w_cout;

        assign w_p = a[i] ^ b[i];
        assign w_g = a[i] & b[i];

        if (i == 0) begin : g_lsb
            assign w_cin = 1'b0;
        end else begin : g_chain
            assign w_cin = g_bit[i-1].w_cout;
        end

        assign w_cout = w_g | (w_p & w_cin);
        assign y[i]   = w_p ^ w_cin;
    end

    // Carry-out is discarded; clock and reset drive nothing.
    logic w_unused;
    assign w_unused = &{1'b0, clock, reset, g_bit[WIDTH-1].w_cout};

endmodule

// File: tb/tb_adder_i8_i8_i8.sv
// Randomised and directed checks of adder_i8_i8_i8 against an arithmetic model.
module tb_adder_i8_i8_i8;

    logic       clock;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;

    int checks;
    int failures;

    adder_i8_i8_i8 #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] model_sum(input int x, input int z);
        return 8'((x + z) % 256);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        a     = 8'd9;
        b     = 8'd3;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            if (i == 8) begin
                checks++;
                if (y !== 8'd12) begin
                    failures++;
                    $display("FAIL reset_hold: y=%0d expected=%0d", y, 12);
                end
            end
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (y !== 8'd12) begin
            failures++;
            $display("FAIL reset_release: y=%0d expected=%0d", y, 12);
        end
    endtask

    task automatic test_wrap();
        int ta[3] = '{255, 127, 128};
        int tb_[3] = '{1, 1, 128};
        int te[3] = '{0, 128, 0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            a = 8'(ta[i]);
            b = 8'(tb_[i]);
            #1;
            checks++;
            if (y !== 8'(te[i])) begin
                failures++;
                $display("FAIL wrap_%0d: a=%0d b=%0d y=%0d expected=%0d", i, ta[i], tb_[i], y, te[i]);
            end
        end
    endtask

    task automatic test_patterns();
        @(negedge clock);
        a = 8'hAA;
        b = 8'h55;
        #1;
        checks++;
        if (y !== 8'hFF) begin
            failures++;
            $display("FAIL pattern_aa_55: y=%02h expected=ff", y);
        end
        @(negedge clock);
        a = 8'h55;
        b = 8'h55;
        #1;
        checks++;
        if (y !== 8'hAA) begin
            failures++;
            $display("FAIL pattern_55_55: y=%02h expected=aa", y);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int ra;
            int rb;
            int sa;
            int sb;
            int ssum;
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            @(negedge clock);
            a = 8'(ra);
            b = 8'(rb);
            if (i % 7 == 3) reset = 1'b1;
            else reset = 1'b0;
            @(posedge clock);
            #1;
            checks++;
            if (y !== model_sum(ra, rb)) begin
                failures++;
                $display("FAIL random_unsigned: a=%0d b=%0d y=%0d expected=%0d", ra, rb, y, model_sum(ra, rb));
            end
            // Signed view: two's-complement sum wrapped into [-128, 127].
            sa = (ra > 127) ? ra - 256 : ra;
            sb = (rb > 127) ? rb - 256 : rb;
            ssum = sa + sb;
            if (ssum > 127) ssum -= 256;
            if (ssum < -128) ssum += 256;
            checks++;
            if ($signed(y) !== 8'(ssum)) begin
                failures++;
                $display("FAIL random_signed: a=%0d b=%0d y=%0d expected=%0d", sa, sb, $signed(y), ssum);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        for (int ia = 0; ia < 256; ia++) begin
            reset = (ia >= 100 && ia < 140) ? 1'b1 : 1'b0;
            for (int ib = 0; ib < 256; ib++) begin
                a = 8'(ia);
                b = 8'(ib);
                #1;
                checks++;
                if (y !== model_sum(ia, ib)) begin
                    failures++;
                    $display("FAIL sweep: a=%0d b=%0d reset=%0b y=%0d expected=%0d", ia, ib, reset, y, model_sum(ia, ib));
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        a        = 8'd0;
        b        = 8'd0;
        test_reset();
        test_wrap();
        test_patterns();
        test_random();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
